// File: rtl/postinc_feeder_if.sv
// postinc_feeder_if: request/load/drain bundle for postinc_feeder.
// The optional sat signal is present only when POSTINC_FEEDER_SATURATE_EN is defined.
interface postinc_feeder_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] cnt;
`ifdef POSTINC_FEEDER_SATURATE_EN
    logic             sat;

    // Producer side drives requests and drains the FIFO.
    modport master (
        output req_valid, load, load_val, out_ready,
        input  req_ready, out_valid, out_data, cnt, sat
    );

    // The feeder block itself.
    modport slave (
        input  req_valid, load, load_val, out_ready,
        output req_ready, out_valid, out_data, cnt, sat
    );
`else
    // Producer side drives requests and drains the FIFO.
    modport master (
        output req_valid, load, load_val, out_ready,
        input  req_ready, out_valid, out_data, cnt
    );

    // The feeder block itself.
    modport slave (
        input  req_valid, load, load_val, out_ready,
        output req_ready, out_valid, out_data, cnt
    );
`endif
endinterface

// File: rtl/postinc_feeder.sv
// postinc_feeder: registered post-increment counter feeding a small FIFO.
// Each accepted request enqueues the pre-increment count and then bumps it.
// Optional feature macro: POSTINC_FEEDER_SATURATE_EN (saturating increment plus sat output).
module postinc_feeder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    postinc_feeder_if.slave bus
);
    // Pointer width; DEPTH is a power of two so pointers wrap naturally.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Occupancy needs one extra bit to represent DEPTH itself.
    localparam int OW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [OW-1:0]               occ;
    logic [WIDTH-1:0]            cnt_q;
    logic [WIDTH-1:0]            cnt_inc;
    logic                        ready;
    logic                        valid;
    logic                        push;
    logic                        pop;

    // Ready depends only on registered occupancy, never on out_ready.
    assign ready = (occ < OW'(DEPTH));
    assign valid = (occ != '0);
    assign push  = bus.req_valid & ready;
    assign pop   = valid & bus.out_ready;

    assign bus.req_ready = ready;
    assign bus.out_valid = valid;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.cnt       = cnt_q;

`ifdef POSTINC_FEEDER_SATURATE_EN
    // Saturating step: all-ones sticks until a load moves it.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
    assign bus.sat = (cnt_q == '1);
`else
    // Wrapping step: all-ones rolls over to zero.
    assign cnt_inc = cnt_q + WIDTH'(1);
`endif

    // Counter: load beats increment; a push alongside a load still enqueues the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.load) begin
            cnt_q <= bus.load_val;
        end else if (push) begin
            cnt_q <= cnt_inc;
        end
    end

    // Storage: cleared on reset so out_data reads zero while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (push) begin
            mem[wr_ptr] <= cnt_q;
        end
    end

    // Pointers advance independently and wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Occupancy tracks full/empty; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_postinc_feeder.sv
// tb_postinc_feeder: directed plus random stimulus against a queue-based model.
// The driver updates the model and pushes expected values; a separate monitor
// pops and compares whenever the DUT completes an output handshake.
module tb_postinc_feeder;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    postinc_feeder_if #(.WIDTH(WIDTH)) bus ();

    postinc_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: the queue is the FIFO contents, model_cnt the counter.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] model_cnt = '0;
    bit  known     = 1'b0;
    bit  clr_pend  = 1'b0;
    bit  after_rst = 1'b0;
    bit  armed     = 1'b0;
    bit  chk_zero  = 1'b0;
    int  cur_occ   = 0;
    logic [WIDTH-1:0] cur_cnt = '0;

    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // One cycle of stimulus: drive inputs just after the edge and advance the model.
    task automatic step(input bit r, input bit rv, input bit ld,
                        input logic [WIDTH-1:0] lv, input bit ordy);
        bit p;
        @(posedge clk);
        #1;
        if (clr_pend) begin
            q.delete();
            model_cnt = '0;
            clr_pend  = 1'b0;
            known     = 1'b1;
        end
        rst           = r;
        bus.req_valid = rv;
        bus.load      = ld;
        bus.load_val  = lv;
        bus.out_ready = ordy;
        cur_occ   = q.size();
        cur_cnt   = model_cnt;
        chk_zero  = after_rst;
        after_rst = r;
        armed     = known;
        if (r) begin
            clr_pend = 1'b1;
        end else if (known) begin
            p = rv && (cur_occ < DEPTH);
            if (p) q.push_back(model_cnt);
            if (ld) model_cnt = lv;
            else if (p) begin
`ifdef POSTINC_FEEDER_SATURATE_EN
                if (model_cnt != 4'hF) model_cnt = model_cnt + 1'b1;
`else
                model_cnt = model_cnt + 1'b1;
`endif
            end
        end
    endtask

    // Monitor: check flags and counter every cycle, pop/compare on each output handshake.
    always @(negedge clk) begin
        if (armed) begin
            check("req_ready", int'(bus.req_ready), int'(cur_occ < DEPTH));
            check("out_valid", int'(bus.out_valid), int'(cur_occ != 0));
            check("cnt", int'(bus.cnt), int'(cur_cnt));
`ifdef POSTINC_FEEDER_SATURATE_EN
            check("sat", int'(bus.sat), int'(cur_cnt == 4'hF));
`endif
            if (chk_zero) check("out_data_after_rst", int'(bus.out_data), 0);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("pop_with_empty_model", 1, 0);
                end else begin
                    check("out_data", int'(bus.out_data), int'(q.pop_front()));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.load      = 1'b0;
        bus.load_val  = '0;
        bus.out_ready = 1'b0;

        // Reset, then a single push with the consumer stalled.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_valid", int'(bus.out_valid), 1);
        check("t1_data", int'(bus.out_data), 0);
        check("t1_cnt", int'(bus.cnt), 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_full_cnt", int'(bus.cnt), 2);
        check("t1_full_ready", int'(bus.req_ready), 0);
        check("t1_full_data", int'(bus.out_data), 0);

        // Drain the full FIFO.
        step(0, 0, 0, 0, 1);
        @(negedge clk);
        check("drain0", int'(bus.out_data), 0);
        step(0, 0, 0, 0, 1);
        @(negedge clk);
        check("drain1", int'(bus.out_data), 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("drained_valid", int'(bus.out_valid), 0);
        check("drained_ready", int'(bus.req_ready), 1);

        // Wrap (or saturate) at all-ones.
        step(0, 0, 1, 4'hF, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        @(negedge clk);
        check("wrap_data", int'(bus.out_data), 15);
`ifdef POSTINC_FEEDER_SATURATE_EN
        check("sat_cnt", int'(bus.cnt), 15);
        check("sat_flag", int'(bus.sat), 1);
`else
        check("wrap_cnt", int'(bus.cnt), 0);
`endif
        step(0, 0, 0, 0, 0);

        // Load and push together: old value enqueued, load wins.
        step(0, 0, 1, 4'd5, 0);
        step(0, 1, 1, 4'd9, 0);
        step(0, 0, 0, 0, 1);
        @(negedge clk);
        check("ldpush_data", int'(bus.out_data), 5);
        check("ldpush_cnt", int'(bus.cnt), 9);
        step(0, 0, 0, 0, 0);

        // Streaming at occupancy 1: one value per cycle.
        step(0, 0, 1, 4'd0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 1);
            @(negedge clk);
            check("stream_data", int'(bus.out_data), i);
            check("stream_ready", int'(bus.req_ready), 1);
            check("stream_valid", int'(bus.out_valid), 1);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Reset with two entries queued and busy inputs.
        step(0, 0, 1, 4'd5, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 1, 4'd3, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_cnt", int'(bus.cnt), 0);

        // Random traffic with occasional loads and resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 7) == 0,
                 WIDTH'($urandom),
                 $urandom_range(0, 9) < 6);
        end

        // Drain what is left.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("final_empty", int'(bus.out_valid), 0);
        check("model_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
